// File: rtl/timer_array.sv
// Multi-channel interval timer with an Avalon-MM register slave.
// Each channel is a prescaled down-counter with one-shot/periodic reload and a level irq.

module timer_chan #(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_ctrl,
  input  logic              wr_period,
  input  logic              wr_status,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [3:0][31:0]  rd_word,
  output logic              irq
);

  localparam int CW = COUNT_WIDTH;
  localparam int PW = PRESCALE_WIDTH;

  logic          run, cont, ito, to;
  logic [PW-1:0] prescale, presc;
  logic [CW-1:0] period, count;
  logic [31:0]   ctrl_word, period_word, ctrl_new, period_new;
  logic          start_wr, start_val, tick, expire, to_clr;
  logic          unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (lanes[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    ctrl_word               = '0;
    ctrl_word[0]            = run;
    ctrl_word[1]            = cont;
    ctrl_word[2]            = ito;
    ctrl_word[8 +: PW]      = prescale;
    period_word             = '0;
    period_word[CW-1:0]     = period;
  end

  assign ctrl_new   = merge(ctrl_word, wdata, be);
  assign period_new = merge(period_word, wdata, be);
  assign start_wr   = wr_ctrl & be[0];
  assign start_val  = wdata[0];
  // A START write (either value) preempts the tick on that edge.
  assign tick       = run & ~start_wr & (presc == prescale);
  assign expire     = tick & (count == '0);
  assign to_clr     = wr_status & be[0] & wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      cont     <= 1'b0;
      ito      <= 1'b0;
      to       <= 1'b0;
      prescale <= '0;
      presc    <= '0;
      period   <= '0;
      count    <= '0;
    end else begin
      if (wr_ctrl) begin
        cont     <= ctrl_new[1];
        ito      <= ctrl_new[2];
        prescale <= ctrl_new[8 +: PW];
      end
      if (wr_period) period <= period_new[CW-1:0];
      // Expiry beats a same-edge clear.
      to <= expire | (to & ~to_clr);
      if (start_wr) begin
        run <= start_val;
        if (start_val) begin
          count <= period;
          presc <= '0;
        end
      end else if (run) begin
        if (presc == prescale) begin
          presc <= '0;
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            count <= cont ? period : '0;
            run   <= cont;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign rd_word[0] = ctrl_word;
  assign rd_word[1] = period_word;
  assign rd_word[2] = 32'(count);
  assign rd_word[3] = {30'b0, run, to};
  assign irq        = to & ito;

  assign unused_bits = ^{ctrl_new, period_new};

endmodule

module timer_array #(
  parameter int NUM_TIMERS     = 4,
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                  pheriphal_clk_clk,
  input  logic                  pheriphal_reset_reset_n,
  input  logic [5:0]            mapped_slave_address,
  input  logic [31:0]           mapped_slave_writedata,
  input  logic [3:0]            mapped_slave_byteenable,
  input  logic                  mapped_slave_write,
  input  logic                  mapped_slave_read,
  output logic [31:0]           mapped_slave_readdata,
  output logic                  mapped_slave_readdatavalid,
  output logic                  mapped_slave_waitrequest,
  output logic [NUM_TIMERS-1:0] timer_irq
);

  logic [3:0]                       ch;
  logic [1:0]                       rsel;
  logic [NUM_TIMERS-1:0][3:0][31:0] rd_words;
  logic [31:0]                      rd_mux;

  assign ch   = mapped_slave_address[5:2];
  assign rsel = mapped_slave_address[1:0];

  for (genvar c = 0; c < NUM_TIMERS; c++) begin : g_chan
    logic hit;
    assign hit = mapped_slave_write & (ch == 4'(c));

    timer_chan #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_chan (
      .clk       (pheriphal_clk_clk),
      .rst_n     (pheriphal_reset_reset_n),
      .wr_ctrl   (hit & (rsel == 2'd0)),
      .wr_period (hit & (rsel == 2'd1)),
      .wr_status (hit & (rsel == 2'd3)),
      .wdata     (mapped_slave_writedata),
      .be        (mapped_slave_byteenable),
      .rd_word   (rd_words[c]),
      .irq       (timer_irq[c])
    );
  end

  // Unpopulated channels fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_TIMERS; c++)
      if (ch == 4'(c)) rd_mux = rd_words[c][rsel];
  end

  always_ff @(posedge pheriphal_clk_clk or negedge pheriphal_reset_reset_n) begin
    if (!pheriphal_reset_reset_n) begin
      mapped_slave_readdata      <= '0;
      mapped_slave_readdatavalid <= 1'b0;
    end else begin
      mapped_slave_readdatavalid <= mapped_slave_read;
      mapped_slave_readdata      <= mapped_slave_read ? rd_mux : '0;
    end
  end

  assign mapped_slave_waitrequest = 1'b0;

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: cycle-level reference model checked every cycle, plus directed timing checks.
module tb_timer_array;
  localparam int NT = 4, CW = 32, PW = 8;
  localparam longint unsigned CMASK = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_be, b_be;
  logic        a_wr, a_rd, b_wr, b_rd, a_rdv, b_rdv, a_wait, b_wait;
  logic [NT-1:0] a_irq;
  logic [0:0]  b_irq;

  timer_array #(.NUM_TIMERS(NT), .COUNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) u_dut (
    .pheriphal_clk_clk(clk), .pheriphal_reset_reset_n(rst_n),
    .mapped_slave_address(a_addr), .mapped_slave_writedata(a_wdata),
    .mapped_slave_byteenable(a_be), .mapped_slave_write(a_wr), .mapped_slave_read(a_rd),
    .mapped_slave_readdata(a_rdata), .mapped_slave_readdatavalid(a_rdv),
    .mapped_slave_waitrequest(a_wait), .timer_irq(a_irq));

  timer_array #(.NUM_TIMERS(1), .COUNT_WIDTH(8), .PRESCALE_WIDTH(2)) u_dut8 (
    .pheriphal_clk_clk(clk), .pheriphal_reset_reset_n(rst_n),
    .mapped_slave_address(b_addr), .mapped_slave_writedata(b_wdata),
    .mapped_slave_byteenable(b_be), .mapped_slave_write(b_wr), .mapped_slave_read(b_rd),
    .mapped_slave_readdata(b_rdata), .mapped_slave_readdatavalid(b_rdv),
    .mapped_slave_waitrequest(b_wait), .timer_irq(b_irq));

  int vecs = 0, errs = 0, cyc = 0;
  bit chk_en = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (main DUT) ----------------
  bit          m_start[NT], m_cont[NT], m_ito[NT], m_to[NT];
  int unsigned m_ps[NT], m_presc[NT];
  logic [31:0] m_period[NT], m_count[NT];
  bit          m_rdv;
  logic [31:0] m_rdata;

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw,
                                      input logic [3:0] lanes);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (lanes[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrl_of(input int c);
    return {16'b0, 8'(m_ps[c]), 5'b0, m_ito[c], m_cont[c], m_start[c]};
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    int c = int'(a[5:2]);
    if (c >= NT) return 32'h0;
    case (a[1:0])
      2'd0:    return ctrl_of(c);
      2'd1:    return m_period[c];
      2'd2:    return m_count[c];
      default: return {30'b0, m_start[c], m_to[c]};
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] rv = m_read(a_addr);
    int ch = int'(a_addr[5:2]);
    int r  = int'(a_addr[1:0]);
    for (int c = 0; c < NT; c++) begin
      bit here = a_wr && (ch == c);
      bit exp_ = 0, clr = 0;
      logic [31:0] cw = ctrl_of(c);
      if (here && r == 0 && a_be[0]) begin
        if (a_wdata[0]) begin
          m_count[c] = m_period[c]; m_presc[c] = 0; m_start[c] = 1;
        end else m_start[c] = 0;
      end else if (m_start[c]) begin
        if (m_presc[c] == m_ps[c]) begin
          m_presc[c] = 0;
          if (m_count[c] != 0) m_count[c] = m_count[c] - 1;
          else begin
            exp_ = 1;
            if (m_cont[c]) m_count[c] = m_period[c];
            else begin m_count[c] = 0; m_start[c] = 0; end
          end
        end else m_presc[c] = (m_presc[c] + 1) % (1 << PW);
      end
      if (here && r == 0) begin
        cw = mrg(cw, a_wdata, a_be);
        m_cont[c] = cw[1]; m_ito[c] = cw[2]; m_ps[c] = int'(cw[15:8]);
      end
      if (here && r == 1) m_period[c] = mrg(m_period[c], a_wdata, a_be) & 32'(CMASK);
      if (here && r == 3 && a_be[0] && a_wdata[0]) clr = 1;
      m_to[c] = exp_ | (m_to[c] & !clr);
    end
    m_rdv   = a_rd;
    m_rdata = a_rd ? rv : 32'h0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NT; c++) begin
        m_start[c] = 0; m_cont[c] = 0; m_ito[c] = 0; m_to[c] = 0;
        m_ps[c] = 0; m_presc[c] = 0; m_period[c] = 0; m_count[c] = 0;
      end
      m_rdv = 0; m_rdata = 0;
    end else model_step();
  end

  // Per-cycle compare of the main DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NT-1:0] ei;
      for (int c = 0; c < NT; c++) ei[c] = m_to[c] & m_ito[c];
      chk("rdv", 32'(a_rdv), 32'(m_rdv));
      if (m_rdv) chk("rdata", a_rdata, m_rdata);
      chk("irq", 32'(a_irq), 32'(ei));
      chk("waitreq", 32'(a_wait), 32'h0);
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic drive(input bit t, input bit w, input bit r, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (t) begin b_wr = w; b_rd = r; b_addr = a; b_wdata = d; b_be = be; end
    else   begin a_wr = w; a_rd = r; a_addr = a; a_wdata = d; a_be = be; end
  endtask

  task automatic wr(input bit t, input logic [5:0] a, input logic [31:0] d,
                    input logic [3:0] be = 4'hF);
    drive(t, 1, 0, a, d, be);
    @(negedge clk);
    drive(t, 0, 0, a, 32'h0, 4'h0);
  endtask

  task automatic rd(input bit t, input logic [5:0] a, output logic [31:0] d);
    drive(t, 0, 1, a, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_valid", 32'(t ? b_rdv : a_rdv), 32'h1);
    d = t ? b_rdata : a_rdata;
    drive(t, 0, 0, a, 32'h0, 4'h0);
  endtask

  task automatic wait_irq(input bit t, input int idx, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((t ? b_irq[idx] : a_irq[idx]) === 1'b1) begin at = cyc; return; end
    end
    chk("irq_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int e0, r1, r2;
    rst_n = 1'b0;
    drive(0, 0, 0, 6'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 6'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(a_irq), 32'h0);
    chk("rst_rdv", 32'(a_rdv), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values across the full address space.
    for (int i = 0; i < 64; i++) begin
      rd(0, 6'(i), d);
      chk("rst_read", d, 32'h0);
    end

    // One-shot, PERIOD 9, PRESCALE 0.
    wr(0, 6'd1, 32'd9);
    wr(0, 6'd0, 32'h5);
    e0 = cyc;
    wait_irq(0, 0, 40, r1);
    chk("oneshot_latency", 32'(r1 - e0), 32'd10);
    rd(0, 6'd3, d); chk("oneshot_status", d, 32'h1);
    rd(0, 6'd2, d); chk("oneshot_count", d, 32'h0);
    repeat (50) @(negedge clk);
    rd(0, 6'd3, d); chk("oneshot_status_late", d, 32'h1);
    rd(0, 6'd2, d); chk("oneshot_count_late", d, 32'h0);
    wr(0, 6'd3, 32'h1);
    chk("oneshot_irq_clr", 32'(a_irq[0]), 32'h0);

    // Periodic with prescaler 4: interval (3+1)*(4+1) = 20.
    wr(0, 6'd5, 32'd3);
    wr(0, 6'd4, 32'h0407);
    e0 = cyc;
    wait_irq(0, 1, 60, r1);
    chk("periodic_first", 32'(r1 - e0), 32'd20);
    wr(0, 6'd7, 32'h1);
    chk("periodic_irq_clr", 32'(a_irq[1]), 32'h0);
    wait_irq(0, 1, 60, r2);
    chk("periodic_interval", 32'(r2 - r1), 32'd20);
    // Same-cycle read and write of PERIOD: read sees the old value.
    drive(0, 1, 1, 6'd5, 32'h55, 4'hF);
    @(negedge clk);
    chk("rw_same_cycle", a_rdata, 32'd3);
    drive(0, 0, 0, 6'd0, 32'h0, 4'h0);
    wr(0, 6'd4, 32'h0);
    wr(0, 6'd7, 32'h1);

    // Byte enables and out-of-range channel.
    wr(0, 6'd13, 32'hAABBCCDD, 4'h3);
    rd(0, 6'd13, d); chk("byteenable", d, 32'h0000CCDD);
    wr(0, 6'd21, 32'h12345678);
    rd(0, 6'd21, d); chk("out_of_range", d, 32'h0);

    // Clear colliding with an expiry edge (PERIOD 0 expires every cycle).
    wr(0, 6'd9, 32'h0);
    wr(0, 6'd8, 32'h3);
    repeat (3) @(negedge clk);
    wr(0, 6'd11, 32'h1);
    rd(0, 6'd11, d); chk("collision_status", d, 32'h3);
    wr(0, 6'd8, 32'h0);
    wr(0, 6'd11, 32'h1);
    rd(0, 6'd11, d); chk("collision_cleared", d, 32'h0);

    // 8-bit counter instance.
    wr(1, 6'd1, 32'h1FF);
    rd(1, 6'd1, d); chk("w8_period", d, 32'hFF);
    wr(1, 6'd0, 32'h5);
    e0 = cyc;
    wait_irq(1, 0, 300, r1);
    chk("w8_latency", 32'(r1 - e0), 32'd256);
    chk("w8_waitreq", 32'(b_wait), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int c = $urandom_range(0, 5);
      int r = $urandom_range(0, 3);
      logic [31:0] dd;
      logic [3:0] be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      case (r)
        0: dd = ($urandom & 32'hFFFF00F8) | (32'($urandom_range(0, 3)) << 8)
                | 32'($urandom_range(0, 7));
        1: dd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
        default: dd = $urandom;
      endcase
      drive(0, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
            6'({c[3:0], r[1:0]}), dd, be);
      @(negedge clk);
    end
    drive(0, 0, 0, 6'h0, 32'h0, 4'h0);

    // Reset while counting.
    wr(0, 6'd5, 32'd5);
    wr(0, 6'd4, 32'h7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_irq", 32'(a_irq), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, 6'd6, d); chk("midrst_count", d, 32'h0);
    rd(0, 6'd7, d); chk("midrst_status", d, 32'h0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
